alu_reg_sequencer: RTL and testbench

- Command-driven controller that sequences the shared ALU and the 4-bit control register as one accumulator datapath.
- Accepts one command per valid/ready handshake and drives the register's control strobes and the ALU operands.
- Repeats the operation a programmable number of times, then returns the final register value on a valid/ready response channel.
- Sits between the host/test sequencer and the existing alu and register instances. The ALU and register themselves are not instantiated inside this block.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_reg_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_reg_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU/register sequencer: opcodes, FSM encoding,
// default widths and a small opcode classification helper.
package alu_seq_pkg;

    localparam int W_DEFAULT    = 4;
    localparam int REPW_DEFAULT = 3;

    // Command opcodes; 8..15 select an ALU operation with alu_oc = op[2:0].
    localparam logic [3:0] OP_READ     = 4'd0;
    localparam logic [3:0] OP_CLR      = 4'd1;
    localparam logic [3:0] OP_LOAD     = 4'd2;
    localparam logic [3:0] OP_INC      = 4'd3;
    localparam logic [3:0] OP_DEC      = 4'd4;
    localparam logic [3:0] OP_SHR      = 4'd5;
    localparam logic [3:0] OP_SHL      = 4'd6;
    localparam logic [3:0] OP_RSVD     = 4'd7;
    localparam logic [3:0] OP_ALU_BASE = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // ALU opcodes occupy the upper half of the opcode space.
    function automatic logic is_alu_op(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/alu_reg_sequencer.sv
// Command sequencer driving an external ALU and control register as one
// accumulator datapath. One command per handshake, repeated rep+1 times,
// final register value returned on the response channel.
module alu_reg_sequencer
    import alu_seq_pkg::*;
#(
    parameter int W    = W_DEFAULT,
    parameter int REPW = REPW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [3:0]      cmd_op,
    input  logic [W-1:0]    cmd_data,
    input  logic [REPW-1:0] cmd_rep,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [W-1:0]    rsp_data,
    output logic            rsp_err,
    output logic            reg_cl,
    output logic            reg_ld,
    output logic            reg_inc,
    output logic            reg_dec,
    output logic            reg_sr,
    output logic            reg_ir,
    output logic            reg_sl,
    output logic            reg_il,
    output logic [W-1:0]    reg_in,
    input  logic [W-1:0]    reg_out,
    output logic [2:0]      alu_oc,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    input  logic [W-1:0]    alu_f
);

    state_t          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [W-1:0]    data_q, data_d;
    logic [REPW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    // State and latched-command registers; async reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Next-state, iteration counter, response capture and strobe decode.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        reg_cl  = 1'b0;
        reg_ld  = 1'b0;
        reg_inc = 1'b0;
        reg_dec = 1'b0;
        reg_sr  = 1'b0;
        reg_ir  = 1'b0;
        reg_sl  = 1'b0;
        reg_il  = 1'b0;
        reg_in  = '0;
        alu_oc  = 3'd0;
        alu_a   = '0;
        alu_b   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    cnt_d   = cmd_rep;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                // One strobe set per cycle; each iteration reads reg_out as
                // left by the previous edge, so repeated ALU ops accumulate.
                if (is_alu_op(op_q)) begin
                    alu_oc = op_q[2:0];
                    alu_a  = reg_out;
                    alu_b  = data_q;
                    reg_ld = 1'b1;
                    reg_in = alu_f;
                end else begin
                    case (op_q)
                        OP_CLR:  reg_cl = 1'b1;
                        OP_LOAD: begin
                            reg_ld = 1'b1;
                            reg_in = data_q;
                        end
                        OP_INC:  reg_inc = 1'b1;
                        OP_DEC:  reg_dec = 1'b1;
                        OP_SHR: begin
                            reg_sr = 1'b1;
                            reg_ir = data_q[0];
                        end
                        OP_SHL: begin
                            reg_sl = 1'b1;
                            reg_il = data_q[0];
                        end
                        default: ; // READ and reserved: no register activity
                    endcase
                end

                if (cnt_q == '0) begin
                    state_d = ST_CAPT;
                end else begin
                    cnt_d = cnt_q - REPW'(1);
                end
            end

            ST_CAPT: begin
                rsp_data_d = reg_out;
                rsp_err_d  = (op_q == OP_RSVD);
                state_d    = ST_RESP;
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Directed bench for alu_reg_sequencer with behavioural register and ALU.
module tb_alu_reg_sequencer;

    localparam int W    = 4;
    localparam int REPW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [3:0]      cmd_op = '0;
    logic [W-1:0]    cmd_data = '0;
    logic [REPW-1:0] cmd_rep = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [W-1:0]    rsp_data;
    logic            rsp_err;
    logic            reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il;
    logic [W-1:0]    reg_in;
    logic [W-1:0]    reg_out;
    logic [2:0]      alu_oc;
    logic [W-1:0]    alu_a, alu_b, alu_f;

    int checks = 0;
    int failures = 0;

    // Observations gathered by run_cmd
    int           n_cl, n_ld, n_inc, n_dec, n_sr, n_ir, n_sl, n_il, n_multi, lat;
    logic [W-1:0] ld_a [8];
    logic [W-1:0] ld_in [8];
    logic [W-1:0] got_data;
    logic         got_err;
    logic         timed_out;

    always #5 clk = ~clk;

    alu_reg_sequencer #(.W(W), .REPW(REPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_rep(cmd_rep),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
        .reg_sr(reg_sr), .reg_ir(reg_ir), .reg_sl(reg_sl), .reg_il(reg_il),
        .reg_in(reg_in), .reg_out(reg_out),
        .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f)
    );

    // Behavioural control register (not reset by the sequencer's reset).
    logic [W-1:0] reg_val = '0;
    assign reg_out = reg_val;
    always @(posedge clk) begin
        if (reg_cl)       reg_val <= '0;
        else if (reg_ld)  reg_val <= reg_in;
        else if (reg_inc) reg_val <= reg_val + 4'd1;
        else if (reg_dec) reg_val <= reg_val - 4'd1;
        else if (reg_sr)  reg_val <= {reg_ir, reg_val[W-1:1]};
        else if (reg_sl)  reg_val <= {reg_val[W-2:0], reg_il};
    end

    // Behavioural ALU; code 0 is add.
    always_comb begin
        case (alu_oc)
            3'd0: alu_f = alu_a + alu_b;
            3'd1: alu_f = alu_a - alu_b;
            3'd2: alu_f = alu_a & alu_b;
            3'd3: alu_f = alu_a | alu_b;
            3'd4: alu_f = alu_a ^ alu_b;
            3'd5: alu_f = ~alu_a;
            3'd6: alu_f = alu_b;
            default: alu_f = alu_a;
        endcase
    end

    // Issue one command, observe strobes each cycle until the response, then
    // complete the handshake with rsp_ready high.
    task automatic run_cmd(input logic [3:0] op, input logic [W-1:0] data,
                           input logic [REPW-1:0] rep);
        int cyc;
        int wait_cnt;
        n_cl = 0; n_ld = 0; n_inc = 0; n_dec = 0; n_sr = 0; n_ir = 0;
        n_sl = 0; n_il = 0; n_multi = 0; lat = 0; timed_out = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_rep = rep;
        rsp_ready = 1'b1;
        wait_cnt = 0;
        #1;
        while (!cmd_ready && wait_cnt < 20) begin
            @(negedge clk); #1;
            wait_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 4'hF; cmd_data = 4'hF; cmd_rep = '1;
        cyc = 1;
        forever begin
            #1;
            if (rsp_valid) break;
            if (reg_cl)  n_cl++;
            if (reg_ld)  begin ld_a[n_ld % 8] = alu_a; ld_in[n_ld % 8] = reg_in; n_ld++; end
            if (reg_inc) n_inc++;
            if (reg_dec) n_dec++;
            if (reg_sr)  n_sr++;
            if (reg_ir)  n_ir++;
            if (reg_sl)  n_sl++;
            if (reg_il)  n_il++;
            if ((32'(reg_cl) + 32'(reg_ld) + 32'(reg_inc) + 32'(reg_dec)
                 + 32'(reg_sr) + 32'(reg_sl)) > 1) n_multi++;
            if (cyc > 30) begin timed_out = 1'b1; break; end
            @(negedge clk);
            cyc++;
        end
        lat = cyc - 1;
        got_data = rsp_data;
        got_err  = rsp_err;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (timed_out) begin
            failures++;
            $display("FAIL timeout op=%0d: rsp_valid never rose", op);
        end
        $display("cmd op=%0d data=%b rep=%0d -> rsp_data=%b err=%0d lat=%0d", op, data, rep, got_data, got_err, lat);
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 4'b0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got ready=%b valid=%b data=%b err=%b, want 1 0 0000 0",
                     cmd_ready, rsp_valid, rsp_data, rsp_err);
        end
        checks++;
        if ({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il} !== 8'b0
            || reg_in !== 4'b0 || alu_oc !== 3'b0 || alu_a !== 4'b0 || alu_b !== 4'b0) begin
            failures++;
            $display("FAIL reset_strobes: got strobes=%b reg_in=%b alu_oc=%b, want all 0",
                     {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il}, reg_in, alu_oc);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load;
        run_cmd(4'd2, 4'b1010, 3'd0);
        checks++;
        if (n_ld !== 1 || ld_in[0] !== 4'b1010 || n_multi !== 0) begin
            failures++;
            $display("FAIL load_strobe: got n_ld=%0d reg_in=%b multi=%0d, want 1 1010 0", n_ld, ld_in[0], n_multi);
        end
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL load_latency: got %0d, want 2", lat);
        end
        checks++;
        if (got_data !== 4'b1010 || got_err !== 1'b0) begin
            failures++;
            $display("FAIL load_rsp: got %b err=%b, want 1010 err=0", got_data, got_err);
        end
    endtask

    task automatic test_inc_dec;
        run_cmd(4'd2, 4'b0000, 3'd0);
        run_cmd(4'd3, 4'b0000, 3'd5);
        checks++;
        if (n_inc !== 6 || n_ld !== 0 || n_multi !== 0 || lat !== 7) begin
            failures++;
            $display("FAIL inc_rep5: got n_inc=%0d n_ld=%0d lat=%0d, want 6 0 7", n_inc, n_ld, lat);
        end
        checks++;
        if (got_data !== 4'b0110) begin
            failures++;
            $display("FAIL inc_rsp: got %b, want 0110", got_data);
        end
        run_cmd(4'd2, 4'b0000, 3'd0);
        run_cmd(4'd4, 4'b0000, 3'd0);
        checks++;
        if (n_dec !== 1 || got_data !== 4'b1111) begin
            failures++;
            $display("FAIL dec_wrap: got n_dec=%0d data=%b, want 1 1111", n_dec, got_data);
        end
    endtask

    task automatic test_alu_accum;
        run_cmd(4'd2, 4'b0011, 3'd0);
        run_cmd(4'd8, 4'b0001, 3'd2);
        checks++;
        if (n_ld !== 3 || ld_a[0] !== 4'b0011 || ld_a[1] !== 4'b0100 || ld_a[2] !== 4'b0101) begin
            failures++;
            $display("FAIL alu_operands: got n_ld=%0d a=%b,%b,%b, want 3 0011,0100,0101",
                     n_ld, ld_a[0], ld_a[1], ld_a[2]);
        end
        checks++;
        if (ld_in[2] !== 4'b0110 || got_data !== 4'b0110) begin
            failures++;
            $display("FAIL alu_rsp: got reg_in=%b data=%b, want 0110 0110", ld_in[2], got_data);
        end
    endtask

    task automatic test_shift;
        run_cmd(4'd2, 4'b1000, 3'd0);
        run_cmd(4'd5, 4'b0001, 3'd1);
        checks++;
        if (n_sr !== 2 || n_ir !== 2 || got_data !== 4'b1110) begin
            failures++;
            $display("FAIL shr: got n_sr=%0d n_ir=%0d data=%b, want 2 2 1110", n_sr, n_ir, got_data);
        end
        run_cmd(4'd6, 4'b0000, 3'd0);
        checks++;
        if (n_sl !== 1 || n_il !== 0 || got_data !== 4'b1100) begin
            failures++;
            $display("FAIL shl: got n_sl=%0d n_il=%0d data=%b, want 1 0 1100", n_sl, n_il, got_data);
        end
    endtask

    task automatic test_clr;
        run_cmd(4'd1, 4'b0111, 3'd0);
        checks++;
        if (n_cl !== 1 || got_data !== 4'b0000) begin
            failures++;
            $display("FAIL clr: got n_cl=%0d data=%b, want 1 0000", n_cl, got_data);
        end
        run_cmd(4'd2, 4'b1100, 3'd0);
    endtask

    // Reserved opcode with a stalled response and a command waiting behind it.
    task automatic test_reserved_stall;
        int strobes;
        int cyc;
        int bad;
        strobes = 0; bad = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'd7; cmd_data = 4'b1001; cmd_rep = 3'd0;
        @(posedge clk);
        @(negedge clk);
        // Next command is presented immediately and must wait.
        cmd_op = 4'd2; cmd_data = 4'b0101; cmd_rep = 3'd0;
        cyc = 0;
        #1;
        while (!rsp_valid && cyc < 20) begin
            if ({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il} !== 8'b0) strobes++;
            if (cmd_ready) bad++;
            @(negedge clk); #1;
            cyc++;
        end
        checks++;
        if (!rsp_valid || strobes !== 0 || rsp_data !== 4'b1100 || rsp_err !== 1'b1) begin
            failures++;
            $display("FAIL rsvd_rsp: got valid=%b strobes=%0d data=%b err=%b, want 1 0 1100 1",
                     rsp_valid, strobes, rsp_data, rsp_err);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_data !== 4'b1100 || rsp_err !== 1'b1 || cmd_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || reg_val !== 4'b1100) begin
            failures++;
            $display("FAIL rsvd_stall: got %0d unstable cycles reg=%b, want 0 1100", bad, reg_val);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || reg_ld !== 1'b0) begin
            failures++;
            $display("FAIL rsvd_release: got ready=%b valid=%b ld=%b, want 1 0 0", cmd_ready, rsp_valid, reg_ld);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        checks++;
        if (reg_ld !== 1'b1 || reg_in !== 4'b0101) begin
            failures++;
            $display("FAIL pending_accept: got ld=%b reg_in=%b, want 1 0101", reg_ld, reg_in);
        end
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (reg_val !== 4'b0101) begin
            failures++;
            $display("FAIL pending_result: got %b, want 0101", reg_val);
        end
        $display("rsvd op=7 stalled 4 cycles then pending LOAD 0101 -> reg=%b", reg_val);
    endtask

    task automatic test_reset_abort;
        int seen;
        run_cmd(4'd2, 4'b0000, 3'd0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'd3; cmd_data = 4'b0000; cmd_rep = 3'd7;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (reg_inc !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre: got inc=%b in 3rd EXEC cycle, want 1", reg_inc);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il} !== 8'b0
            || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset: got strobes=%b ready=%b valid=%b, want 0 1 0",
                     {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il}, cmd_ready, rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (rsp_valid || reg_inc) seen++;
        end
        rsp_ready = 1'b0;
        checks++;
        if (seen !== 0 || reg_val !== 4'b0010) begin
            failures++;
            $display("FAIL abort_after: got %0d active cycles reg=%b, want 0 0010", seen, reg_val);
        end
        $display("abort INC rep=7 in 3rd cycle -> reg=%b", reg_val);
    endtask

    initial begin
        test_reset();
        test_load();
        test_inc_dec();
        test_alu_accum();
        test_shift();
        test_reserved_stall();
        test_clr();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
